// File: rtl/halfband_27_serializer.sv
`default_nettype none
// ============================================================================
// Module : halfband_27_serializer
// Rounds and saturates the 8-channel halfband output word, buffers whole
// words in a small FIFO and streams one tagged channel per valid/ready beat.
// Rev    : 1.0  initial release
// ============================================================================
module halfband_27_serializer #(
  parameter int SHIFT = 8,
  parameter int OW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       c,
  input  logic                       reset_n,
  input  logic [191:0]               id,
  input  logic                       iv,
  output logic [OW-1:0]              od,
  output logic [2:0]                 ochan,
  output logic                       olast,
  output logic                       ovalid,
  input  logic                       oready,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_LW = $clog2(DEPTH + 1);
  localparam int C_WW = 8 * OW;
  localparam logic signed [24:0] C_BIAS = 25'((1 << SHIFT) >> 1);
  localparam logic signed [24:0] C_MAX  = 25'((1 << (OW - 1)) - 1);
  localparam logic signed [24:0] C_MIN  = -C_MAX - 25'sd1;

  logic [C_WW-1:0] w_rnd;

  for (genvar k = 0; k < 8; k++) begin : g_ch
    logic signed [24:0] w_t;
    logic signed [24:0] w_s;
    assign w_t = $signed({id[24*k+23], id[24*k +: 24]}) + C_BIAS;
    assign w_s = w_t >>> SHIFT;
    assign w_rnd[OW*k +: OW] = (w_s > C_MAX) ? C_MAX[OW-1:0] :
                               (w_s < C_MIN) ? C_MIN[OW-1:0] : w_s[OW-1:0];
  end

  logic [C_WW-1:0] r_rword;
  logic            r_rvalid;

  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rword  <= '0;
    end else begin
      r_rvalid <= iv;
      if (iv) r_rword <= w_rnd;
    end
  end

  logic [C_WW-1:0] r_mem [DEPTH];
  logic [C_AW-1:0] r_wptr;
  logic [C_AW-1:0] r_rptr;
  logic [C_LW-1:0] r_level;
  logic            r_overflow;
  logic            r_busy;
  logic [2:0]      r_chan;
  logic [C_WW-1:0] r_word;

  logic w_hs;
  logic w_done;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // A word leaves the FIFO when it moves into the output word register,
  // which is either an idle output stage or the channel-7 handshake.
  assign w_hs    = r_busy & oready;
  assign w_done  = w_hs & (r_chan == 3'd7);
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == C_LW'(DEPTH));
  assign w_pop   = !w_empty & (!r_busy | w_done);
  assign w_push  = r_rvalid & (!w_full | w_pop);

  always_ff @(posedge c) begin
    if (w_push) r_mem[r_wptr] <= r_rword;
  end

  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + C_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + C_AW'(1);
      if (w_push & !w_pop)      r_level <= r_level + C_LW'(1);
      else if (!w_push & w_pop) r_level <= r_level - C_LW'(1);
      if (r_rvalid & !w_push) r_overflow <= 1'b1;
    end
  end

  // On the last-channel handshake without a waiting word the counter
  // simply wraps to 0 and the stage goes idle.
  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_chan <= 3'd0;
      r_word <= '0;
    end else if (w_pop) begin
      r_word <= r_mem[r_rptr];
      r_busy <= 1'b1;
      r_chan <= 3'd0;
    end else if (w_hs) begin
      if (w_done) r_busy <= 1'b0;
      r_chan <= r_chan + 3'd1;
    end
  end

  assign od       = r_word[OW*r_chan +: OW];
  assign ochan    = r_chan;
  assign olast    = (r_chan == 3'd7);
  assign ovalid   = r_busy;
  assign overflow = r_overflow;
  assign level    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_halfband_27_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_halfband_27_serializer
// Randomized scenario bench with an arithmetic rounding model and beat queues.
// Rev    : 1.0  initial release
// ============================================================================
module tb_halfband_27_serializer;

  localparam int SHIFT = 8;
  localparam int OW    = 16;
  localparam int DEPTH = 4;

  logic          c       = 1'b0;
  logic          reset_n = 1'b0;
  logic [191:0]  id      = '0;
  logic          iv      = 1'b0;
  logic          oready  = 1'b0;
  logic [OW-1:0] od;
  logic [2:0]    ochan;
  logic          olast;
  logic          ovalid;
  logic          overflow;
  logic [2:0]    level;

  int n_vec = 0;
  int n_err = 0;
  logic [19:0] got_q[$];
  logic [19:0] exp_q[$];

  halfband_27_serializer #(.SHIFT(SHIFT), .OW(OW), .DEPTH(DEPTH)) dut (
    .c(c), .reset_n(reset_n), .id(id), .iv(iv), .od(od), .ochan(ochan),
    .olast(olast), .ovalid(ovalid), .oready(oready), .overflow(overflow),
    .level(level)
  );

  always #5 c = ~c;

  function automatic logic [OW-1:0] ref_sample(input logic [23:0] x);
    longint v, d, q, hi, lo;
    v  = longint'($signed(x));
    d  = longint'(1) << SHIFT;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -hi - 1;
    v  = v + d / 2;
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q[OW-1:0];
  endfunction

  function automatic logic [191:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic add_exp(input logic [191:0] w);
    for (int ch = 0; ch < 8; ch++)
      exp_q.push_back({ch == 7, 3'(ch), ref_sample(w[24*ch +: 24])});
  endtask

  // Drive one cycle from a negedge; a beat is captured when it will handshake.
  task automatic step(input logic rdy, input logic pulse, input logic [191:0] w);
    oready = rdy;
    iv     = pulse;
    id     = pulse ? w : rand_word();
    if (ovalid && rdy) got_q.push_back({olast, ochan, od});
    @(negedge c);
  endtask

  task automatic test_reset();
    @(negedge c);
    @(negedge c);
    n_vec++; if (ovalid !== 1'b0)   begin n_err++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
    n_vec++; if (od !== '0)         begin n_err++; $display("FAIL reset_od: got %h expected 0", od); end
    n_vec++; if (ochan !== 3'd0)    begin n_err++; $display("FAIL reset_ochan: got %0d expected 0", ochan); end
    n_vec++; if (olast !== 1'b0)    begin n_err++; $display("FAIL reset_olast: got %b expected 0", olast); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_vec++; if (level !== 3'd0)    begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0);
  endtask

  task automatic test_single();
    logic [191:0] w;
    logic [15:0]  req [8];
    int first, last, nv;
    logic [19:0] g;
    req = '{16'd1, 16'd1, 16'd0, 16'hFFFF, 16'h7FFF, 16'h8000, 16'd0, 16'd1};
    w = {24'h000100, 24'h000000, 24'h800000, 24'h7FFFFF,
         24'hFFFF7F, 24'hFFFF80, 24'h00017F, 24'h000080};
    got_q.delete();
    first = -1; last = -1; nv = 0;
    step(1'b1, 1'b1, w);
    for (int i = 1; i <= 14; i++) begin
      if (ovalid) begin
        if (first < 0) first = i;
        last = i;
        nv++;
      end
      step(1'b1, 1'b0, '0);
    end
    n_vec++; if (first !== 3) begin n_err++; $display("FAIL single_latency: got %0d expected 3", first); end
    n_vec++; if (nv !== 8 || last !== 10) begin n_err++; $display("FAIL single_contiguous: got %0d beats ending %0d expected 8 ending 10", nv, last); end
    n_vec++; if (got_q.size() !== 8) begin n_err++; $display("FAIL single_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_vec++;
      if (g !== {i == 7, 3'(i), req[i]}) begin
        n_err++; $display("FAIL single_beat%0d: got %h expected %h", i, g, {i == 7, 3'(i), req[i]});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [191:0] w;
    logic [18:0]  held;
    logic         prev_stall, rdy;
    logic [19:0]  g;
    got_q.delete(); exp_q.delete();
    w = rand_word();
    add_exp(w);
    step(1'b0, 1'b1, w);
    prev_stall = 1'b0;
    held = '0;
    for (int j = 0; j < 60; j++) begin
      rdy = (j % 3 == 0);
      if (prev_stall) begin
        n_vec++;
        if ({od, ochan} !== held) begin n_err++; $display("FAIL bp_stable: got %h expected %h", {od, ochan}, held); end
      end
      prev_stall = ovalid && !rdy;
      held = {od, ochan};
      step(rdy, 1'b0, '0);
    end
    n_vec++; if (got_q.size() !== 8) begin n_err++; $display("FAIL bp_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_vec++;
      if (g !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d: got %h expected %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_fill();
    logic [191:0] w;
    logic [19:0]  g;
    got_q.delete(); exp_q.delete();
    for (int p = 0; p < 6; p++) begin
      w = rand_word();
      if (p < 5) add_exp(w);
      step(1'b0, 1'b1, w);
      for (int k = 0; k < 15; k++) step(1'b0, 1'b0, '0);
      if (p == 3) begin
        n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL fill_level4th: got %0d expected 3", level); end
        n_vec++; if (ovalid !== 1'b1 || ochan !== 3'd0) begin n_err++; $display("FAIL fill_head: got v=%b ch=%0d expected v=1 ch=0", ovalid, ochan); end
      end
      if (p == 4) begin
        n_vec++; if (level !== 3'd4 || overflow !== 1'b0) begin n_err++; $display("FAIL fill_5th: got level=%0d ovf=%b expected level=4 ovf=0", level, overflow); end
      end
      if (p == 5) begin
        n_vec++; if (level !== 3'd4 || overflow !== 1'b1) begin n_err++; $display("FAIL fill_6th: got level=%0d ovf=%b expected level=4 ovf=1", level, overflow); end
      end
    end
    for (int k = 0; k < 80; k++) step(1'b1, 1'b0, '0);
    n_vec++; if (got_q.size() !== 40) begin n_err++; $display("FAIL fill_count: got %0d expected 40", got_q.size()); end
    for (int i = 0; i < 40; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_vec++;
      if (g !== exp_q[i]) begin n_err++; $display("FAIL fill_beat%0d: got %h expected %h", i, g, exp_q[i]); end
    end
    n_vec++; if (level !== 3'd0 || ovalid !== 1'b0) begin n_err++; $display("FAIL fill_drain: got level=%0d v=%b expected level=0 v=0", level, ovalid); end
  endtask

  task automatic test_simul_pop();
    logic [191:0] w;
    logic [19:0]  g;
    int since;
    reset_n = 1'b0;
    step(1'b0, 1'b0, '0);
    reset_n = 1'b1;
    got_q.delete(); exp_q.delete();
    for (int p = 0; p < 5; p++) begin
      w = rand_word();
      add_exp(w);
      step(1'b0, 1'b1, w);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0);
    n_vec++; if (level !== 3'd4 || overflow !== 1'b0) begin n_err++; $display("FAIL simul_full: got level=%0d ovf=%b expected level=4 ovf=0", level, overflow); end
    since = -1;
    for (int k = 0; k < 80; k++) begin
      if (since < 0 && ovalid && ochan == 3'd6) begin
        w = rand_word();
        add_exp(w);
        step(1'b1, 1'b1, w);
        since = 0;
      end else begin
        step(1'b1, 1'b0, '0);
        if (since >= 0) since++;
      end
      if (since == 1) begin
        n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL simul_level: got %0d expected 4", level); end
      end
    end
    n_vec++; if (since < 0) begin n_err++; $display("FAIL simul_sent: got no pulse expected pulse at channel 6"); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_overflow: got %b expected 0", overflow); end
    n_vec++; if (got_q.size() !== 48) begin n_err++; $display("FAIL simul_count: got %0d expected 48", got_q.size()); end
    for (int i = 0; i < 48; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_vec++;
      if (g !== exp_q[i]) begin n_err++; $display("FAIL simul_beat%0d: got %h expected %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [191:0] w1, w2;
    logic [19:0]  g;
    int first, last, nv;
    got_q.delete(); exp_q.delete();
    w1 = rand_word(); w2 = rand_word();
    add_exp(w1); add_exp(w2);
    first = -1; last = -1; nv = 0;
    for (int i = 0; i < 30; i++) begin
      if (ovalid) begin
        if (first < 0) first = i;
        last = i;
        nv++;
      end
      step(1'b1, (i == 0) || (i == 2), (i == 0) ? w1 : w2);
    end
    n_vec++; if (nv !== 16 || last - first + 1 !== 16) begin n_err++; $display("FAIL b2b_gapless: got %0d beats over %0d cycles expected 16 over 16", nv, last - first + 1); end
    n_vec++; if (got_q.size() !== 16) begin n_err++; $display("FAIL b2b_count: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < 16; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_vec++;
      if (g !== exp_q[i]) begin n_err++; $display("FAIL b2b_beat%0d: got %h expected %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [191:0] w;
    logic [19:0]  g;
    got_q.delete();
    step(1'b1, 1'b1, rand_word());
    for (int i = 0; i < 20; i++) begin
      if (ovalid && ochan == 3'd3) break;
      step(1'b1, 1'b0, '0);
    end
    n_vec++; if (ovalid !== 1'b1 || ochan !== 3'd3) begin n_err++; $display("FAIL mid_reach: got v=%b ch=%0d expected v=1 ch=3", ovalid, ochan); end
    step(1'b0, 1'b1, rand_word());
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0);
    n_vec++; if (level !== 3'd1 || ochan !== 3'd3) begin n_err++; $display("FAIL mid_stall: got level=%0d ch=%0d expected level=1 ch=3", level, ochan); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (ovalid !== 1'b0) begin n_err++; $display("FAIL mid_async_ovalid: got %b expected 0", ovalid); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL mid_async_level: got %0d expected 0", level); end
    @(negedge c);
    step(1'b1, 1'b0, '0);
    reset_n = 1'b1;
    got_q.delete(); exp_q.delete();
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, '0);
    n_vec++; if (got_q.size() !== 0) begin n_err++; $display("FAIL mid_no_resume: got %0d beats expected 0", got_q.size()); end
    w = rand_word();
    add_exp(w);
    step(1'b1, 1'b1, w);
    for (int k = 0; k < 14; k++) step(1'b1, 1'b0, '0);
    n_vec++; if (got_q.size() !== 8) begin n_err++; $display("FAIL mid_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_vec++;
      if (g !== exp_q[i]) begin n_err++; $display("FAIL mid_beat%0d: got %h expected %h", i, g, exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_simul_pop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
